instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Multicycle control sequencer for the Risco-5 core. It owns the program counter and the instruction register, and runs the fetch handshake with instruction/data memory. It drives the current instruction to the immediate generator, steps the datapath through decode, execute, memory and writeback, and computes the next PC from the generated immediate, the ALU result and the branch flag.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded at reset.
- `TIMEOUT_CYCLES`, default 16: memory-ack watchdog limit (used only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_rd`  out  1  memory read request (fetch or load).
- `mem_wr`  out  1  memory write request (store).
- `mem_addr_sel`  out  1  0 = address is `pc`; 1 = address is the ALU result.
- `mem_ack`  in  1  memory completion, sampled each cycle while a request is held.
- `instr_data`  in  32  fetched instruction word, valid when `mem_ack` is high in FETCH.
- `ir`  out  32  instruction register; feeds the immediate generator and decoder.
- `immediate`  in  32  immediate-generator output for `ir`.
- `alu_result`  in  32  ALU output; used as the JALR target and the load/store address.
- `branch_taken`  in  1  ALU compare result, valid in EXECUTE.
- `pc`  out  32  current program counter.
- `alu_en`  out  1  high for the single EXECUTE cycle.
- `reg_write`  out  1  one-cycle register-file write strobe.
- `trap`  out  1  sticky fault indicator.
- `trap_cause`  out  2  0 = illegal opcode, 1 = misaligned target, 2 = memory timeout.

## Operation
States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- **IDLE:** entered from reset; held for exactly 1 cycle, then → FETCH.
- **FETCH:** `mem_rd`=1, `mem_addr_sel`=0.
  - On `mem_ack`, `ir` ← `instr_data` and the state → DECODE.
  - Otherwise the request is held.
- **DECODE:** 1 cycle, during which `immediate` settles.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - Any other opcode → TRAP with cause 0.
- **EXECUTE:** `alu_en`=1 for 1 cycle.
  - Loads and stores → MEMORY.
  - All other opcodes → WRITEBACK.
- **MEMORY:** `mem_addr_sel`=1, with `mem_rd`=1 for loads and `mem_wr`=1 for stores.
  - Requests are held until `mem_ack`, then → WRITEBACK.
- **WRITEBACK:** 1 cycle.
  - `reg_write`=1 except for stores and branches.
  - The PC is updated, then → FETCH.
- **Next-PC rules (32-bit, wrap modulo 2^32):**
  - Branch taken: `pc`+4+`immediate`. The branch immediate arrives pre-biased by −4.
  - Branch not taken: `pc`+4.
  - JAL: `pc`+`immediate`.
  - JALR: {`alu_result`[31:1],1'b0}.
  - All other opcodes: `pc`+4.
- **Alignment check:** a computed target with bit 1 set → TRAP with cause 1. The PC is not updated and `reg_write` stays 0.
- **TRAP:** all request and strobe outputs are 0; `trap`=1. The block stays in TRAP until reset.

## Timing
- **Reset values:** `pc`=`RESET_VECTOR`, `ir`=0, `trap`=0, `trap_cause`=0. `mem_rd`, `mem_wr`, `mem_addr_sel`, `alu_en` and `reg_write` are all 0.
- **Reset behaviour:** asserting reset forces IDLE immediately, in any state and mid-handshake. Requests drop without waiting for `mem_ack`.
- **Handshake:**
  - `mem_ack` may arrive in the same cycle the request is first asserted; the state advances on that edge.
  - `mem_ack` outside FETCH or MEMORY is ignored.
  - `mem_rd` and `mem_wr` are never high together.
- **Cycle counts with zero-wait memory:**
  - ALU, LUI, AUIPC, JAL, JALR and branch instructions take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Loads and stores take 5 cycles.
  - Each wait cycle adds 1 cycle.
- **Output timing:** all outputs are registered or decoded from the state register only; no combinational path runs from `mem_ack` to `mem_rd` or `mem_wr`.
- **Register updates:** `pc` changes only on the WRITEBACK edge. `ir` changes only on a FETCH edge with `mem_ack` high.

## Configuration
- **`SEQ_TIMEOUT_EN` defined:**
  - A counter, sized for `TIMEOUT_CYCLES`, counts consecutive cycles in FETCH or MEMORY without `mem_ack`.
  - The counter clears on `mem_ack` and on every state entry.
  - When the count reaches `TIMEOUT_CYCLES`, the block goes to TRAP with cause 2 and drops its requests.
- **`SEQ_TIMEOUT_EN` undefined:** no counter is built, the block waits indefinitely, and cause 2 never occurs.

## Test plan
- **Reset vector:** reset release with `RESET_VECTOR`=0x100 → IDLE for 1 cycle, then `mem_rd`=1 with `pc`=0x100.
- **ALU instruction:** fetch of `addi` 0x00500093 with immediate ack → `alu_en` on cycle 3, `reg_write` on cycle 4, then `pc`=0x104.
- **Branch:** `beq` at `pc`=0x200 with immediate input 0x0C and `branch_taken`=1 → `pc`=0x210; with `branch_taken`=0 → `pc`=0x204.
- **Load with wait states:** `lw` with `mem_ack` delayed 3 cycles in MEMORY → `mem_rd` and `mem_addr_sel` held for 4 cycles, `reg_write` 1 cycle later, 8 cycles total.
- **Faults:**
  - Opcode 0x7F → `trap`=1 with `trap_cause`=0.
  - JALR with `alu_result`=0x302 → `trap_cause`=1 and `pc` unchanged.
- **Watchdog (macro defined):** no ack for 16 cycles in FETCH → `trap_cause`=2. Reset asserted mid-wait → IDLE with `trap`=0.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - memory handshake bundle between the sequencer and instruction/data memory
// Purpose: groups the fetch/load/store request signals and the memory response.
// Signals:
//   mem_rd        read request (fetch or load), driven by the sequencer
//   mem_wr        write request (store), driven by the sequencer
//   mem_addr_sel  0 = address is pc, 1 = address is the ALU result
//   mem_ack       memory completion, driven by the memory
//   instr_data    fetched instruction word, valid with mem_ack during a fetch
// Modports: master = sequencer side, slave = memory side.
interface instruction_sequencer_if;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_addr_sel;
    logic        mem_ack;
    logic [31:0] instr_data;

    modport master (
        output mem_rd,
        output mem_wr,
        output mem_addr_sel,
        input  mem_ack,
        input  instr_data
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  mem_addr_sel,
        output mem_ack,
        output instr_data
    );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multicycle fetch/decode/execute/memory/writeback control sequencer
// Purpose: owns pc and ir, runs the memory handshake and computes the next pc.
// Ports:
//   clk           core clock, rising edge
//   reset         asynchronous active-low reset
//   mem           instruction_sequencer_if.master (mem_rd, mem_wr, mem_addr_sel, mem_ack, instr_data)
//   ir            instruction register to immediate generator / decoder
//   immediate     immediate-generator output for ir
//   alu_result    ALU output (JALR target, load/store address)
//   branch_taken  ALU compare result, valid in EXECUTE
//   pc            current program counter
//   alu_en        high for the single EXECUTE cycle
//   reg_write     register-file write strobe in WRITEBACK
//   trap          sticky fault flag
//   trap_cause    0 illegal opcode, 1 misaligned target, 2 memory timeout
// Build option: SEQ_TIMEOUT_EN adds a memory-ack watchdog of TIMEOUT_CYCLES cycles.
module instruction_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    instruction_sequencer_if.master        mem,
    output logic [31:0]                    ir,
    input  logic [31:0]                    immediate,
    input  logic [31:0]                    alu_result,
    input  logic                           branch_taken,
    output logic [31:0]                    pc,
    output logic                           alu_en,
    output logic                           reg_write,
    output logic                           trap,
    output logic [1:0]                     trap_cause
);
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] ir_q, ir_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_addr_sel_q, mem_addr_sel_d;
    logic        alu_en_q, alu_en_d;
    logic        reg_write_q, reg_write_d;
    logic        trap_q, trap_d;
    logic [1:0]  trap_cause_q, trap_cause_d;

    logic [6:0]  opcode;
    logic        is_load, is_store, is_branch, legal;
    logic [31:0] target;
    logic        timeout_hit;

    assign opcode    = ir_q[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Next-pc candidate, evaluated in EXECUTE when branch_taken and alu_result are valid.
    // The branch immediate is pre-biased by -4, hence the extra +4.
    always_comb begin
        target = pc_q + 32'd4;
        case (opcode)
            OP_BRANCH: if (branch_taken) target = pc_q + 32'd4 + immediate;
            OP_JAL:    target = pc_q + immediate;
            OP_JALR:   target = alu_result & 32'hFFFF_FFFE;
            default:   target = pc_q + 32'd4;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // wait_cnt_q holds the number of earlier ack-less cycles in this wait state,
    // so the limit is reached on the TIMEOUT_CYCLES-th ack-less cycle.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEMORY))
            && !mem.mem_ack) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        ir_d         = ir_q;
        trap_cause_d = trap_cause_q;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem.mem_ack) begin
                    ir_d    = mem.instr_data;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd0;
                end
            end
            S_EXECUTE: begin
                npc_d = target;
                if (target[1]) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd1;
                end else if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem.mem_ack) begin
                    state_d = S_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end
            end
            S_WRITEBACK: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Strobes are registered from the next state, so they line up with the
        // state register and never depend combinationally on mem_ack.
        mem_rd_d       = (state_d == S_FETCH) || ((state_d == S_MEMORY) && is_load);
        mem_wr_d       = (state_d == S_MEMORY) && is_store;
        mem_addr_sel_d = (state_d == S_MEMORY);
        alu_en_d       = (state_d == S_EXECUTE);
        reg_write_d    = (state_d == S_WRITEBACK) && !is_store && !is_branch;
        trap_d         = trap_q || (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_VECTOR;
            npc_q          <= RESET_VECTOR;
            ir_q           <= 32'd0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            alu_en_q       <= 1'b0;
            reg_write_q    <= 1'b0;
            trap_q         <= 1'b0;
            trap_cause_q   <= 2'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            npc_q          <= npc_d;
            ir_q           <= ir_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_sel_q <= mem_addr_sel_d;
            alu_en_q       <= alu_en_d;
            reg_write_q    <= reg_write_d;
            trap_q         <= trap_d;
            trap_cause_q   <= trap_cause_d;
        end
    end

    assign mem.mem_rd       = mem_rd_q;
    assign mem.mem_wr       = mem_wr_q;
    assign mem.mem_addr_sel = mem_addr_sel_q;
    assign ir               = ir_q;
    assign pc               = pc_q;
    assign alu_en           = alu_en_q;
    assign reg_write        = reg_write_q;
    assign trap             = trap_q;
    assign trap_cause       = trap_cause_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - randomized self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic [31:0] immediate;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] pc;
    logic        alu_en;
    logic        reg_write;
    logic        trap;
    logic [1:0]  trap_cause;

    instruction_sequencer_if bus ();

    instruction_sequencer #(
        .RESET_VECTOR   (RV),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (bus),
        .ir           (ir),
        .immediate    (immediate),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .pc           (pc),
        .alu_en       (alu_en),
        .reg_write    (reg_write),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;

    logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the DUT in its first FETCH cycle.
    task automatic do_reset();
        reset        = 1'b0;
        bus.mem_ack  = 1'b1;
        #1;
        check_eq("rst_async_rd", {31'd0, bus.mem_rd}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc, RV);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_trap", {31'd0, trap}, 32'd0);
        check_eq("rst_cause", {30'd0, trap_cause}, 32'd0);
        check_eq("rst_strobes", {27'd0, bus.mem_rd, bus.mem_wr, bus.mem_addr_sel, alu_en, reg_write}, 32'd0);
        reset       = 1'b1;
        bus.mem_ack = 1'b0;
        #1;
        check_eq("idle_rd", {31'd0, bus.mem_rd}, 32'd0);
        @(negedge clk);
        check_eq("first_fetch", {30'd0, bus.mem_rd, bus.mem_addr_sel}, 32'd2);
        check_eq("first_pc", pc, RV);
        model_pc = RV;
    endtask

    // Runs one instruction as the memory and checks it against the instruction-level model.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic [31:0] imm,
                             input logic [31:0] alu, input logic bt, input int fwait, input int mwait);
        logic [6:0]  op;
        logic        lgl, ldst, exp_trap;
        logic [1:0]  exp_cause;
        logic [31:0] tgt, exp_pc;
        int exp_cyc, exp_alu_cnt, exp_alu_cyc, exp_rw_cnt, exp_rw_cyc, exp_mrd, exp_mwr;
        int cyc, fcnt, mcnt, alu_cnt, alu_cyc, rw_cnt, rw_cyc, mrd, mwr, both;
        logic fetched, done;

        op   = instr[6:0];
        lgl  = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) lgl = 1'b1;
        ldst = (op == 7'b0000011) || (op == 7'b0100011);
        tgt  = model_pc + 32'd4;
        if (op == 7'b1100011 && bt) tgt = model_pc + 32'd4 + imm;
        if (op == 7'b1101111) tgt = model_pc + imm;
        if (op == 7'b1100111) tgt = {alu[31:1], 1'b0};

        exp_alu_cnt = 0; exp_alu_cyc = 0; exp_rw_cnt = 0; exp_rw_cyc = 0;
        exp_mrd = 0; exp_mwr = 0; exp_pc = model_pc; exp_cause = 2'd0;
        if (!lgl) begin
            exp_trap = 1'b1; exp_cause = 2'd0; exp_cyc = fwait + 2;
        end else if (tgt[1]) begin
            exp_trap = 1'b1; exp_cause = 2'd1; exp_cyc = fwait + 3;
            exp_alu_cnt = 1; exp_alu_cyc = fwait + 3;
        end else begin
            exp_trap = 1'b0; exp_pc = tgt;
            exp_alu_cnt = 1; exp_alu_cyc = fwait + 3;
            exp_cyc = fwait + 4 + (ldst ? mwait + 1 : 0);
            if (op != 7'b0100011 && op != 7'b1100011) begin
                exp_rw_cnt = 1; exp_rw_cyc = exp_cyc;
            end
            if (op == 7'b0000011) exp_mrd = mwait + 1;
            if (op == 7'b0100011) exp_mwr = mwait + 1;
        end

        check_eq({name, "_pc_start"}, pc, model_pc);
        bus.instr_data = instr;
        immediate      = imm;
        alu_result     = alu;
        branch_taken   = bt;
        cyc = 0; fcnt = 0; mcnt = 0; alu_cnt = 0; alu_cyc = 0; rw_cnt = 0; rw_cyc = 0;
        mrd = 0; mwr = 0; both = 0; fetched = 1'b0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (trap || (fetched && bus.mem_rd && !bus.mem_addr_sel)) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (alu_en) begin alu_cnt++; alu_cyc = cyc; end
                if (reg_write) begin rw_cnt++; rw_cyc = cyc; end
                if (bus.mem_rd && bus.mem_wr) both++;
                if (bus.mem_rd && !bus.mem_addr_sel && !fetched) begin
                    bus.mem_ack = (fcnt == fwait);
                    if (bus.mem_ack) fetched = 1'b1;
                    fcnt++;
                end else if (bus.mem_addr_sel && (bus.mem_rd || bus.mem_wr)) begin
                    if (bus.mem_rd) mrd++;
                    if (bus.mem_wr) mwr++;
                    bus.mem_ack = (mcnt == mwait);
                    mcnt++;
                end else begin
                    bus.mem_ack = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end

        check_eq({name, "_done"}, {31'd0, done}, 32'd1);
        check_eq({name, "_cycles"}, cyc, exp_cyc);
        check_eq({name, "_ir"}, ir, instr);
        check_eq({name, "_trap"}, {31'd0, trap}, {31'd0, exp_trap});
        check_eq({name, "_pc"}, pc, exp_pc);
        check_eq({name, "_alu_en"}, {alu_cnt[15:0], alu_cyc[15:0]}, {exp_alu_cnt[15:0], exp_alu_cyc[15:0]});
        check_eq({name, "_reg_write"}, {rw_cnt[15:0], rw_cyc[15:0]}, {exp_rw_cnt[15:0], exp_rw_cyc[15:0]});
        check_eq({name, "_mem_rw"}, {mrd[15:0], mwr[15:0]}, {exp_mrd[15:0], exp_mwr[15:0]});
        check_eq({name, "_rd_wr_both"}, both, 32'd0);
        if (exp_trap) begin
            check_eq({name, "_cause"}, {30'd0, trap_cause}, {30'd0, exp_cause});
            check_eq({name, "_trap_quiet"}, {28'd0, bus.mem_rd, bus.mem_wr, alu_en, reg_write}, 32'd0);
            do_reset();
        end else begin
            model_pc = exp_pc;
        end
    endtask

    initial begin
        int n;
        logic [31:0] instr, imm, alu;
        reset        = 1'b1;
        bus.mem_ack  = 1'b0;
        bus.instr_data = 32'd0;
        immediate    = 32'd0;
        alu_result   = 32'd0;
        branch_taken = 1'b0;
        model_pc     = RV;
        @(negedge clk);
        do_reset();

        run_instr("addi", 32'h0050_0093, 32'd5, 32'd5, 1'b0, 0, 0);
        run_instr("jal_to_200", 32'h0000_006F, 32'h0000_00FC, 32'd0, 1'b0, 0, 0);
        run_instr("beq_taken", 32'h0000_0063, 32'h0000_000C, 32'd0, 1'b1, 0, 0);
        run_instr("jal_back", 32'h0000_006F, 32'hFFFF_FFF0, 32'd0, 1'b0, 0, 0);
        run_instr("beq_not_taken", 32'h0000_0063, 32'h0000_000C, 32'd0, 1'b0, 0, 0);
        run_instr("lw_wait3", 32'h0000_A083, 32'd0, 32'h0000_1000, 1'b0, 0, 3);
        run_instr("sw_wait1", 32'h0010_A023, 32'd0, 32'h0000_1004, 1'b0, 2, 1);
        run_instr("illegal_7f", 32'h0000_007F, 32'd0, 32'd0, 1'b0, 0, 0);
        run_instr("jalr_misaligned", 32'h0000_80E7, 32'd0, 32'h0000_0302, 1'b0, 0, 0);

        // Reset dropped in the middle of an unacknowledged fetch.
        bus.mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midfetch_rd_drop", {31'd0, bus.mem_rd}, 32'd0);
        do_reset();

`ifdef SEQ_TIMEOUT_EN
        bus.mem_ack = 1'b0;
        n = 0;
        while (!trap && n < 100) begin
            if (bus.mem_rd) n++;
            @(negedge clk);
        end
        check_eq("wdog_cycles", n, 32'd16);
        check_eq("wdog_cause", {30'd0, trap_cause}, 32'd2);
        check_eq("wdog_rd_drop", {31'd0, bus.mem_rd}, 32'd0);
        do_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("wdog_midwait_trap", {31'd0, trap}, 32'd0);
        do_reset();
`else
        bus.mem_ack = 1'b0;
        n = 0;
        repeat (40) @(negedge clk);
        check_eq("nowdog_trap", {31'd0, trap}, 32'd0);
        check_eq("nowdog_rd_held", {31'd0, bus.mem_rd}, 32'd1);
        do_reset();
`endif

        for (int t = 0; t < 200; t++) begin
            instr = $urandom;
            if ($urandom_range(0, 9) != 0) instr[6:0] = legal_ops[$urandom_range(0, 9)];
            imm = $urandom;
            if ($urandom_range(0, 9) != 0) imm[1:0] = 2'b00;
            alu = $urandom;
            if ($urandom_range(0, 9) != 0) alu[1:0] = 2'b00;
            run_instr($sformatf("rnd%0d", t), instr, imm, alu, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
